// File: rtl/qc_sched_pkg.sv
// Shared types for the timestamp scheduler: widths, FIFO entry layout, run states
// and the modular time comparison used by every channel's head check.
package qc_sched_pkg;

  localparam int TIME_W = 20;
  localparam int WORD_W = 18;

  typedef struct packed {
    logic [TIME_W-1:0] t;
    logic [WORD_W-1:0] word;
  } sched_entry_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sched_state_e;

  // Distance from now to the entry time, mod 2^TIME_W; negative means the entry is in the past.
  function automatic logic signed [TIME_W-1:0] time_delta(input logic [TIME_W-1:0] head_t,
                                                          input logic [TIME_W-1:0] now);
    return $signed(head_t - now);
  endfunction

endpackage

// File: rtl/timestamp_scheduler_if.sv
// Dispatcher-side bus of the scheduler: per-channel timed writes and collision flags in,
// per-channel issue pulses and words out.
interface timestamp_scheduler_if
  import qc_sched_pkg::*;
#(
  parameter int NCH = 4
) ();

  logic [NCH-1:0]        fifo_wr_en;
  logic [TIME_W*NCH-1:0] abs_time;
  logic [WORD_W*NCH-1:0] fifo_wd;
  logic [NCH-1:0]        err_bit;
  logic [NCH-1:0]        issue_valid;
  logic [WORD_W*NCH-1:0] issue_word;

  modport master (
    output fifo_wr_en, abs_time, fifo_wd, err_bit,
    input  issue_valid, issue_word
  );

  modport slave (
    input  fifo_wr_en, abs_time, fifo_wd, err_bit,
    output issue_valid, issue_word
  );

endinterface

// File: rtl/sched_fifo.sv
// Show-ahead FIFO of timestamped entries for one channel; head is valid whenever not empty.
// A write into a full FIFO is taken only when the same cycle also pops.
module sched_fifo
  import qc_sched_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         wr,
  input  sched_entry_t wd,
  input  logic         rd,
  output logic         full,
  output logic         empty,
  output sched_entry_t head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr_q, wr_ptr_d;
  logic [AW:0]  rd_ptr_q, rd_ptr_d;
  sched_entry_t mem_q [DEPTH];
  logic         do_wr, do_rd;

  always_comb begin
    empty    = (wr_ptr_q == rd_ptr_q);
    full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    do_rd    = rd && !empty;
    do_wr    = wr && (!full || do_rd);
    head     = mem_q[rd_ptr_q[AW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage carries no reset; only the pointers define occupancy.
  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wd;
  end

endmodule

// File: rtl/timestamp_scheduler.sv
// Per-channel timed issue scheduler: releases each buffered word when the shared run timer
// reaches its absolute time, under an IDLE/RUN/DONE run controller with sticky error status.
module timestamp_scheduler
  import qc_sched_pkg::*;
#(
  parameter int NCH   = 4,
  parameter int DEPTH = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    stop,
  input  logic                    clear,
  input  logic                    halt_on_err,
  timestamp_scheduler_if.slave    bus,
  output logic [TIME_W-1:0]       timer,
  output logic                    busy,
  output logic                    done,
  output logic [NCH-1:0]          late_err,
  output logic [NCH-1:0]          ovf_err,
  output logic [NCH-1:0]          col_err
);

  sched_state_e state_q, state_d;
  logic [TIME_W-1:0]     timer_q, timer_d;
  logic [NCH-1:0]        late_q, late_d;
  logic [NCH-1:0]        ovf_q, ovf_d;
  logic [NCH-1:0]        col_q, col_d;
  logic [NCH-1:0]        issue_valid_q, issue_valid_d;
  logic [WORD_W*NCH-1:0] issue_word_q, issue_word_d;

  logic                     run, open_win, flush, new_err;
  logic [NCH-1:0]           full, empty, wr_req, pop, match, late_evt, ovf_evt, col_evt;
  sched_entry_t             head [NCH];
  logic signed [TIME_W-1:0] delta [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    sched_entry_t wd;
    assign wd = {bus.abs_time[g*TIME_W +: TIME_W], bus.fifo_wd[g*WORD_W +: WORD_W]};

    sched_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .wr    (wr_req[g]),
      .wd    (wd),
      .rd    (pop[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );
  end

  // Per-channel head check, write acceptance and error events.
  always_comb begin
    run      = (state_q == RUN);
    open_win = (state_q != DONE);
    match    = '0;
    late_evt = '0;
    pop      = '0;
    wr_req   = '0;
    ovf_evt  = '0;
    col_evt  = '0;
    for (int i = 0; i < NCH; i++) begin
      delta[i]    = time_delta(head[i].t, timer_q);
      match[i]    = run && !empty[i] && (delta[i] == '0);
      late_evt[i] = run && !empty[i] && delta[i][TIME_W-1];
      pop[i]      = match[i] || late_evt[i];
      wr_req[i]   = open_win && bus.fifo_wr_en[i];
      ovf_evt[i]  = wr_req[i] && full[i] && !pop[i];
      col_evt[i]  = open_win && bus.err_bit[i];
    end
    new_err = |{late_evt, ovf_evt, col_evt};
  end

  // Run controller; the timer holds on the cycle that leaves RUN.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    flush   = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          timer_d = '0;
        end
      end
      RUN: begin
        if (stop || (halt_on_err && new_err)) state_d = DONE;
        else                                   timer_d = timer_q + 1'b1;
      end
      DONE: begin
        if (clear) begin
          state_d = IDLE;
          timer_d = '0;
          flush   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    late_d        = flush ? '0 : (late_q | late_evt);
    ovf_d         = flush ? '0 : (ovf_q | ovf_evt);
    col_d         = flush ? '0 : (col_q | col_evt);
    issue_valid_d = match;
    issue_word_d  = issue_word_q;
    for (int i = 0; i < NCH; i++) begin
      if (match[i]) issue_word_d[i*WORD_W +: WORD_W] = head[i].word;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      late_q        <= '0;
      ovf_q         <= '0;
      col_q         <= '0;
      issue_valid_q <= '0;
      issue_word_q  <= '0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      late_q        <= late_d;
      ovf_q         <= ovf_d;
      col_q         <= col_d;
      issue_valid_q <= issue_valid_d;
      issue_word_q  <= issue_word_d;
    end
  end

  assign timer           = timer_q;
  assign busy            = (state_q == RUN);
  assign done            = (state_q == DONE);
  assign late_err        = late_q;
  assign ovf_err         = ovf_q;
  assign col_err         = col_q;
  assign bus.issue_valid = issue_valid_q;
  assign bus.issue_word  = issue_word_q;

endmodule

// File: tb/tb_timestamp_scheduler.sv
// Directed bench for timestamp_scheduler: preload/issue timing, late and overflow drops,
// halt on collision, stop/clear/restart, asynchronous reset and the modular time boundary.
module tb_timestamp_scheduler;
  import qc_sched_pkg::*;

  localparam int NCH   = 4;
  localparam int DEPTH = 16;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              start = 1'b0, stop = 1'b0, clear = 1'b0, halt_on_err = 1'b0;
  logic [TIME_W-1:0] timer;
  logic              busy, done;
  logic [NCH-1:0]    late_err, ovf_err, col_err;
  logic [NCH-1:0]    iss_seen;
  int                n_cmp = 0;
  int                n_mis = 0;

  timestamp_scheduler_if #(.NCH(NCH)) bus ();

  timestamp_scheduler #(.NCH(NCH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .halt_on_err (halt_on_err),
    .bus         (bus),
    .timer       (timer),
    .busy        (busy),
    .done        (done),
    .late_err    (late_err),
    .ovf_err     (ovf_err),
    .col_err     (col_err)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    iss_seen |= bus.issue_valid;
  endtask

  function automatic logic [WORD_W-1:0] word_of(input int ch);
    return bus.issue_word[ch*WORD_W +: WORD_W];
  endfunction

  task automatic wr(input int ch, input logic [TIME_W-1:0] t, input logic [WORD_W-1:0] w);
    bus.fifo_wr_en = '0;
    bus.fifo_wr_en[ch] = 1'b1;
    bus.abs_time[ch*TIME_W +: TIME_W] = t;
    bus.fifo_wd[ch*WORD_W +: WORD_W] = w;
    tick();
    bus.fifo_wr_en = '0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic stop_clear();
    stop = 1'b1;
    tick();
    stop = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_timer(input string tag, input logic [TIME_W-1:0] tgt);
    int k = 0;
    while (timer != tgt && k < 200) begin
      tick();
      k++;
    end
    chk_eq(tag, timer, tgt);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int n0, n1, n2, exp_t[3], exp_w[3];
    logic [TIME_W-1:0] tprev;
    logic [WORD_W-1:0] last2;
    exp_t = '{6, 7, 11};
    exp_w = '{1, 2, 3};
    bus.fifo_wr_en = '0;
    bus.abs_time   = '0;
    bus.fifo_wd    = '0;
    bus.err_bit    = '0;
    iss_seen       = '0;

    // Reset state
    #2;
    chk_eq("rst_timer", timer, 0);
    chk_eq("rst_busy_done", {busy, done}, 0);
    chk_eq("rst_flags", {late_err, ovf_err, col_err}, 0);
    chk_eq("rst_issue_valid", bus.issue_valid, 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Preload ch0 (5,6,10) and ch1 (6), then run
    wr(0, 5, 18'h1);
    wr(0, 6, 18'h2);
    wr(0, 10, 18'h3);
    wr(1, 6, 18'h22);
    pulse_start();
    chk_eq("t1_timer0", timer, 0);
    chk_eq("t1_busy", busy, 1);
    n0 = 0;
    n1 = 0;
    for (int c = 0; c < 14; c++) begin
      tick();
      if (bus.issue_valid[0]) begin
        if (n0 < 3) begin
          chk_eq($sformatf("t1_ch0_time%0d", n0), timer, exp_t[n0]);
          chk_eq($sformatf("t1_ch0_word%0d", n0), word_of(0), exp_w[n0]);
        end
        n0++;
      end
      if (bus.issue_valid[1]) begin
        chk_eq("t1_ch1_time", timer, 7);
        chk_eq("t1_ch1_word", word_of(1), 18'h22);
        n1++;
      end
    end
    chk_eq("t1_ch0_count", n0, 3);
    chk_eq("t1_ch1_count", n1, 1);
    chk_eq("t1_flags", {late_err, ovf_err, col_err}, 0);
    stop_clear();

    // Late writes: stale time at timer 8, and a write equal to the current timer
    pulse_start();
    wait_timer("t2_reach8", 8);
    iss_seen = '0;
    wr(1, 3, 18'h33);
    chk_eq("t2_timer_after_wr", timer, 9);
    wr(2, 9, 18'h44);
    tick();
    tick();
    chk_eq("t2_late", late_err, 4'b0110);
    chk_eq("t2_no_issue", iss_seen, 0);
    chk_eq("t2_still_busy", busy, 1);
    stop_clear();
    chk_eq("t2_clear_flags", {late_err, ovf_err, col_err}, 0);

    // Overflow: DEPTH+1 writes in IDLE, exactly DEPTH issue
    for (int k = 0; k <= DEPTH; k++) wr(2, 20'(20 + k), 18'(18'h100 + k));
    chk_eq("t3_ovf", ovf_err, 4'b0100);
    pulse_start();
    n2 = 0;
    last2 = '0;
    for (int c = 0; c < 45; c++) begin
      tick();
      if (bus.issue_valid[2]) begin
        chk_eq($sformatf("t3_time%0d", n2), timer, 21 + n2);
        last2 = word_of(2);
        n2++;
      end
    end
    chk_eq("t3_count", n2, DEPTH);
    chk_eq("t3_last_word", last2, 18'h10F);
    chk_eq("t3_no_late", late_err, 0);
    stop_clear();

    // Collision with halt_on_err: immediate DONE, timer frozen, pending entry held
    halt_on_err = 1'b1;
    wr(3, 50, 18'h55);
    pulse_start();
    wait_timer("t4_reach3", 3);
    bus.err_bit[3] = 1'b1;
    tick();
    bus.err_bit = '0;
    chk_eq("t4_col", col_err, 4'b1000);
    chk_eq("t4_done", {busy, done}, 2'b01);
    chk_eq("t4_timer_frozen", timer, 3);
    iss_seen = '0;
    for (int c = 0; c < 60; c++) tick();
    chk_eq("t4_no_issue", iss_seen, 0);
    chk_eq("t4_timer_still", timer, 3);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    halt_on_err = 1'b0;
    chk_eq("t4_clear_flags", {late_err, ovf_err, col_err}, 0);
    chk_eq("t4_idle", {busy, done, timer}, 0);

    // Stop at timer 4 with a match on that cycle, clear, restart with empty FIFOs
    wr(0, 4, 18'h44);
    pulse_start();
    wait_timer("t5_reach4", 4);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    chk_eq("t5_issue_after_stop", bus.issue_valid, 4'b0001);
    chk_eq("t5_issue_word", word_of(0), 18'h44);
    chk_eq("t5_done", done, 1);
    chk_eq("t5_timer_held", timer, 4);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk_eq("t5_cleared_timer", timer, 0);
    pulse_start();
    chk_eq("t5_restart_timer", timer, 0);
    iss_seen = '0;
    for (int c = 0; c < 60; c++) tick();
    chk_eq("t5_fifos_empty", iss_seen, 0);
    chk_eq("t5_timer60", timer, 60);
    bus.err_bit[0] = 1'b1;
    tick();
    bus.err_bit = '0;
    chk_eq("t5_col_no_halt", {col_err, busy}, {4'b0001, 1'b1});
    chk_eq("t5_word_hold_ch2", word_of(2), 18'h10F);

    // Asynchronous reset mid-run
    #2;
    reset = 1'b0;
    #1;
    chk_eq("t5_rst_timer", timer, 0);
    chk_eq("t5_rst_state", {busy, done}, 0);
    chk_eq("t5_rst_flags", {late_err, ovf_err, col_err}, 0);
    chk_eq("t5_rst_word0", word_of(0), 0);
    chk_eq("t5_rst_word2", word_of(2), 0);
    @(negedge clk);
    reset = 1'b1;
    tick();

    // Modular compare boundary: 0xFFFFF is one step in the past at timer 0, 0x7FFFF is future
    wr(0, 20'hFFFFF, 18'h66);
    wr(1, 20'h7FFFF, 18'h77);
    pulse_start();
    iss_seen = '0;
    tick();
    tick();
    chk_eq("t6_late_boundary", late_err, 4'b0001);
    chk_eq("t6_no_issue", iss_seen, 0);

    // Simultaneous stop and collision with halt enabled
    halt_on_err = 1'b1;
    tprev = timer;
    stop = 1'b1;
    bus.err_bit[2] = 1'b1;
    tick();
    stop = 1'b0;
    bus.err_bit = '0;
    halt_on_err = 1'b0;
    chk_eq("t6_done", {busy, done}, 2'b01);
    chk_eq("t6_col", col_err, 4'b0100);
    tick();
    chk_eq("t6_timer_frozen", timer, tprev);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
